enc_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-input priority-encoder resource between eight requesters. Replaces fixed highest-bit-wins selection with rotating priority, a registered one-hot grant, release and timeout handshakes, and a status word compatible with the existing 5-bit LED layout. Sits between the switch/requester inputs and the encoder/seg display path; `gnt_idx` drives the 3-bit index consumed by the seven-segment decoder.

---
 rtl/enc_arb_pkg.sv | 17 +
 rtl/enc_rr_arbiter_if.sv | 24 ++
 rtl/rr_prio_enc.sv | 33 +++
 rtl/enc_rr_arbiter.sv | 118 +++++++++++
 tb/tb_enc_rr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_arb_pkg.sv
// Shared constants, state type and helpers for the round-robin encoder arbiter.
package enc_arb_pkg;

  localparam int unsigned N_REQ        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned HOLD_MAX_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/enc_rr_arbiter_if.sv
// Request/grant bundle between the requester inputs and the arbiter.
interface enc_rr_arbiter_if;
  import enc_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;
  logic [4:0]       led;

  modport master (
    output en, req, rel,
    input  gnt, gnt_idx, gnt_vld, timeout, led
  );

  modport slave (
    input  en, req, rel,
    output gnt, gnt_idx, gnt_vld, timeout, led
  );

endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: the search starts at ptr and descends with wrap.
module rr_prio_enc
  import enc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_hi;

  // Rotate so that requester ptr lands on the top bit; a plain
  // highest-bit-wins search then gives rotating priority.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = req[IDX_W'(k) + ptr + IDX_W'(1)];
    end
  end

  always_comb begin
    w_hi = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_rot[k]) w_hi = IDX_W'(k);
    end
  end

  assign any     = |req;
  assign win_idx = w_hi + ptr + IDX_W'(1);

endmodule

// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter for the shared 8-input encoder with release/timeout handshakes.
// Optional forced release after HOLD_MAX cycles when ENC_ARB_TIMEOUT_EN is defined.
module enc_rr_arbiter
  import enc_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  enc_rr_arbiter_if.slave  bus
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_vld;
  logic             r_timeout;
  logic [4:0]       r_led;

  logic             w_any;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_to_hit;
  logic             w_norm_end;
  logic             w_end;
  logic             w_to_only;
  logic [IDX_W-1:0] w_nxt_idx;

  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("enc_rr_arbiter: HOLD_MAX must be at least 1");
  end

  rr_prio_enc u_prio_enc (
    .req     (bus.req),
    .ptr     (r_ptr),
    .any     (w_any),
    .win_idx (w_win_idx)
  );

`ifdef ENC_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold;

  assign w_to_hit = (r_state == GRANT) && (r_hold == HOLD_W'(HOLD_MAX - 1));

  // Counts completed grant cycles; cleared in IDLE so each grant starts at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (r_state == IDLE || w_end) begin
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_norm_end = bus.rel | ~bus.req[r_gnt_idx] | ~bus.en;
  assign w_end      = w_norm_end | w_to_hit;
  assign w_to_only  = w_to_hit & ~w_norm_end;

  always_comb begin
    w_nxt_idx = '0;
    case (r_state)
      IDLE:    if (bus.en && w_any) w_nxt_idx = w_win_idx;
      GRANT:   if (!w_end)          w_nxt_idx = r_gnt_idx;
      default: w_nxt_idx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '1;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
      r_timeout <= 1'b0;
      r_led     <= '0;
    end else begin
      r_timeout <= 1'b0;
      r_led     <= {bus.en, |bus.req, w_nxt_idx};
      case (r_state)
        IDLE: begin
          if (bus.en && w_any) begin
            r_state   <= GRANT;
            r_gnt     <= idx_to_onehot(w_win_idx);
            r_gnt_idx <= w_win_idx;
            r_gnt_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (w_end) begin
            // Last grantee drops to lowest priority.
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= r_gnt_idx - 1'b1;
            r_timeout <= w_to_only;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.timeout = r_timeout;
  assign bus.led     = r_led;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Self-checking bench for enc_rr_arbiter; follows ENC_ARB_TIMEOUT_EN like the DUT.
module tb_enc_rr_arbiter;
  import enc_arb_pkg::*;

  localparam int unsigned HM = 15;
`ifdef ENC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  enc_rr_arbiter_if bus();

  enc_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the grant, whose turn is next, how long held.
  bit         m_vld;
  int         m_idx;
  int         m_ptr;
  int         m_hold;
  bit         m_to;
  logic [4:0] m_led;

  function automatic void model_update();
    bit to_hit;
    bit cause;
    if (!rst) begin
      m_vld = 0; m_idx = 0; m_ptr = 7; m_hold = 0; m_to = 0; m_led = '0;
      return;
    end
    m_to = 0;
    if (!m_vld) begin
      if (bus.en && bus.req != 8'h00) begin
        for (int i = 0; i < 8; i++) begin
          if (bus.req[(m_ptr - i + 8) % 8]) begin
            m_idx = (m_ptr - i + 8) % 8;
            break;
          end
        end
        m_vld  = 1;
        m_hold = 0;
      end
    end else begin
      to_hit = TO_EN && (m_hold == int'(HM) - 1);
      cause  = bus.rel || !bus.req[m_idx] || !bus.en;
      if (cause || to_hit) begin
        m_to  = to_hit && !cause;
        m_ptr = (m_idx + 7) % 8;
        m_vld = 0;
        m_idx = 0;
      end else begin
        m_hold++;
      end
    end
    m_led = {bus.en, |bus.req, 3'(m_idx)};
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [7:0] g;
    g = m_vld ? (8'h01 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_vld, m_to, m_led};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout, bus.led};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.en = 1'b1; bus.req = 8'h00; bus.rel = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.en = 1'b1; bus.req = 8'hFF; bus.rel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (obs_vec() !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 18'h0);
      end
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt !== 8'h80 || bus.gnt_idx !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%h idx=%0d expected gnt=80 idx=7", bus.gnt, bus.gnt_idx);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rotation();
    int q[$];
    int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    do_reset();
    bus.req = 8'hFF;
    for (int c = 0; c < 40 && q.size() < 9; c++) begin
      bus.rel = m_vld;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rotation_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (bus.gnt_vld === 1'b1) q.push_back(int'(bus.gnt_idx));
    end
    bus.rel = 1'b0;
    n_tests++;
    if (q.size() != 9) begin
      n_fail++;
      $display("FAIL rotation_count: got %0d grants expected 9", q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (q[i] != exp_seq[i]) begin
          n_fail++;
          $display("FAIL rotation_seq%0d: got %0d expected %0d", i, q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_sparse();
    int q[$];
    int exp_seq[6] = '{7, 2, 7, 2, 7, 2};
    do_reset();
    bus.req = 8'b1000_0100;
    for (int c = 0; c < 30 && q.size() < 6; c++) begin
      bus.rel = m_vld;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sparse_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (bus.gnt_vld === 1'b1) q.push_back(int'(bus.gnt_idx));
    end
    bus.rel = 1'b0;
    n_tests++;
    if (q.size() != 6) begin
      n_fail++;
      $display("FAIL sparse_count: got %0d grants expected 6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (q[i] != exp_seq[i]) begin
          n_fail++;
          $display("FAIL sparse_seq%0d: got %0d expected %0d", i, q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.req = 8'h04;
    tick();
    tick();
    n_tests++;
    if (bus.gnt !== 8'h04) begin
      n_fail++;
      $display("FAIL drop_held: got gnt=%h expected 04", bus.gnt);
    end
    bus.req = 8'h00;
    tick();
    n_tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0 || bus.gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_release: got gnt=%h to=%b vld=%b expected 00/0/0", bus.gnt, bus.timeout, bus.gnt_vld);
    end
    bus.req = 8'hFF;
    tick();
    n_tests++;
    if (bus.gnt_idx !== 3'd1 || bus.gnt !== 8'h02) begin
      n_fail++;
      $display("FAIL drop_next_ptr: got idx=%0d gnt=%h expected 1/02", bus.gnt_idx, bus.gnt);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL drop_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] g_hist[17];
    logic       t_hist[17];
    int held;
    int to_cnt;
    do_reset();
    bus.req = 8'h08;
    held = 0;
    to_cnt = 0;
    for (int c = 0; c < 17; c++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      g_hist[c] = bus.gnt;
      t_hist[c] = bus.timeout;
      if (bus.timeout === 1'b1) to_cnt++;
    end
    for (int c = 0; c < 17; c++) begin
      if (g_hist[c] !== 8'h08) break;
      held++;
    end
`ifdef ENC_ARB_TIMEOUT_EN
    n_tests++;
    if (held != 15 || to_cnt != 1 || t_hist[15] !== 1'b1 || g_hist[16] !== 8'h08) begin
      n_fail++;
      $display("FAIL timeout_len: got held=%0d pulses=%0d to@16=%b regrant=%h expected 15/1/1/08",
               held, to_cnt, t_hist[15], g_hist[16]);
    end
    for (int c = 0; c < 20 && m_hold != int'(HM) - 1; c++) tick();
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    n_tests++;
    if (bus.timeout !== 1'b0 || bus.gnt !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_with_rel: got to=%b gnt=%h expected 0/00", bus.timeout, bus.gnt);
    end
`else
    n_tests++;
    if (held != 17 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_disabled: got held=%0d pulses=%0d expected 17/0", held, to_cnt);
    end
`endif
  endtask

  task automatic test_enable();
    do_reset();
    bus.req = 8'hFF;
    tick();
    bus.en = 1'b0;
    tick();
    n_tests++;
    if (bus.gnt !== 8'h00 || bus.led[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: got gnt=%h led4=%b expected 00/0", bus.gnt, bus.led[4]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (bus.gnt_vld !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL en_low_idle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    bus.en = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL en_regrant: got idx=%0d expected 6", bus.gnt_idx);
    end
    bus.en = 1'b0;
    bus.rel = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL en_rel_same: got gnt=%h to=%b expected 00/0", bus.gnt, bus.timeout);
    end
    bus.en = 1'b1;
    bus.rel = 1'b0;
    tick();
    n_tests++;
    if (bus.gnt_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL en_rel_single_end: got idx=%0d expected 5", bus.gnt_idx);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs_vec() !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_mid_grant: got %h expected %h", obs_vec(), 18'h0);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt !== 8'h80) begin
      n_fail++;
      $display("FAIL rst_ptr_back: got gnt=%h expected 80", bus.gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.req = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 99) != 0);
      bus.en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.req = 8'($urandom) & 8'($urandom);
      bus.rel = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    bus.rel = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.req = 8'h00; bus.rel = 1'b0;
    test_reset();
    test_rotation();
    test_sparse();
    test_req_drop();
    test_timeout();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
